// File: rtl/hub75_pkg.sv
// Shared HUB75 definitions: pixel word layout, on-time FSM states and error bit positions.
// Used by the receive monitor and the panel driver.
package hub75_pkg;

    localparam int PIX_W = 12;

    localparam int R1_BIT = 0;
    localparam int G1_BIT = 1;
    localparam int B1_BIT = 2;
    localparam int R2_BIT = 3;
    localparam int G2_BIT = 4;
    localparam int B2_BIT = 5;
    localparam int R3_BIT = 6;
    localparam int G3_BIT = 7;
    localparam int B3_BIT = 8;
    localparam int R4_BIT = 9;
    localparam int G4_BIT = 10;
    localparam int B4_BIT = 11;

    localparam int ERR_COL_OVF    = 0;
    localparam int ERR_ROW_ONEHOT = 1;
    localparam int ERR_LAT_LIT    = 2;

    typedef enum logic [0:0] {
        ST_DARK = 1'b0,
        ST_LIT  = 1'b1
    } on_state_e;

    function automatic logic onehot32(input logic [31:0] v);
        return (v != 32'd0) && ((v & (v - 32'd1)) == 32'd0);
    endfunction

endpackage

// File: rtl/hub75_edge_det.sv
// Edge detector for one panel control line plus its side-band data bits.
// With HUB75_RX_SYNC_EN defined, signal and data pass a 2-flop synchronizer first.
module hub75_edge_det #(
    parameter int   DW      = 1,
    parameter logic RST_VAL = 1'b0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          sig_i,
    input  logic [DW-1:0] data_i,
    output logic          rise_o,
    output logic          fall_o,
    output logic [DW-1:0] data_o
);

    logic cur_s;
    logic prev_q;
    logic prev_d;

`ifdef HUB75_RX_SYNC_EN
    logic [1:0]    sig_sync_q;
    logic [1:0]    sig_sync_d;
    logic [DW-1:0] data_s1_q;
    logic [DW-1:0] data_s1_d;
    logic [DW-1:0] data_s2_q;
    logic [DW-1:0] data_s2_d;

    // Synchronizer next-state: data travels alongside its qualifying signal.
    always_comb begin
        sig_sync_d = {sig_sync_q[0], sig_i};
        data_s1_d  = data_i;
        data_s2_d  = data_s1_q;
    end

    // Synchronizer registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sig_sync_q <= {2{RST_VAL}};
            data_s1_q  <= '0;
            data_s2_q  <= '0;
        end else begin
            sig_sync_q <= sig_sync_d;
            data_s1_q  <= data_s1_d;
            data_s2_q  <= data_s2_d;
        end
    end

    assign cur_s  = sig_sync_q[1];
    assign data_o = data_s2_q;
`else
    assign cur_s  = sig_i;
    assign data_o = data_i;
`endif

    // Delay stage next-state.
    always_comb begin
        prev_d = cur_s;
    end

    // Delay register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_q <= RST_VAL;
        end else begin
            prev_q <= prev_d;
        end
    end

    assign rise_o = cur_s & ~prev_q;
    assign fall_o = ~cur_s & prev_q;

endmodule

// File: rtl/hub75_rx_monitor.sv
// HUB75 receive monitor: rebuilds pixels, line latches, row selects and lit time from panel pins.
// Define HUB75_RX_SYNC_EN to synchronize the panel bus when it comes from another clock domain.
module hub75_rx_monitor
    import hub75_pkg::*;
#(
    parameter int COLS  = 128,
    parameter int ROWS  = 16,
    parameter int CNT_W = 16,
    parameter int PL_W  = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      r1,
    input  logic                      g1,
    input  logic                      b1,
    input  logic                      r2,
    input  logic                      g2,
    input  logic                      b2,
    input  logic                      r3,
    input  logic                      g3,
    input  logic                      b3,
    input  logic                      r4,
    input  logic                      g4,
    input  logic                      b4,
    input  logic                      clk_out,
    input  logic                      lat,
    input  logic                      blank,
    input  logic                      row_clk,
    input  logic                      row_data,
    output logic                      pix_valid,
    output logic [$clog2(COLS)-1:0]   pix_col,
    output logic [PIX_W-1:0]          pix_data,
    output logic                      line_valid,
    output logic [$clog2(COLS):0]     line_cols,
    output logic [$clog2(ROWS)-1:0]   line_row,
    output logic [PL_W-1:0]           line_plane,
    output logic                      on_valid,
    output logic [CNT_W-1:0]          on_cycles,
    output logic [PL_W-1:0]           on_plane,
    output logic                      frame_start,
    output logic [2:0]                err
);

    localparam int COL_W = $clog2(COLS);
    localparam int ROW_W = $clog2(ROWS);

    localparam logic [COL_W:0]   COL_FULL = (COL_W + 1)'(COLS);
    localparam logic [COL_W:0]   COL_INC  = (COL_W + 1)'(1);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLS - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS - 1);
    localparam logic [PL_W-1:0]  PL_INC   = PL_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    logic [PIX_W-1:0] colour_s;
    logic [PIX_W-1:0] colour_sync_s;
    logic             shift_rise_s;
    logic             shift_fall_s;
    logic             lat_rise_s;
    logic             lat_fall_s;
    logic             lat_data_s;
    logic             blank_rise_s;
    logic             blank_fall_s;
    logic             blank_data_s;
    logic             row_rise_s;
    logic             row_fall_s;
    logic             row_data_s;
    logic             unused_s;
    logic [ROWS-1:0]  row_shift_s;
    logic [ROW_W-1:0] row_enc_s;

    logic [COL_W:0]   col_cnt_q,    col_cnt_d;
    logic [PL_W-1:0]  plane_q,      plane_d;
    logic [PL_W-1:0]  last_plane_q, last_plane_d;
    logic [PL_W-1:0]  lit_plane_q,  lit_plane_d;
    logic [ROWS-1:0]  row_sr_q,     row_sr_d;
    logic [ROW_W-1:0] row_idx_q,    row_idx_d;
    on_state_e        state_q,      state_d;
    logic [CNT_W-1:0] on_cnt_q,     on_cnt_d;
    logic [2:0]       err_q,        err_d;

    logic             pix_valid_q,   pix_valid_d;
    logic [COL_W-1:0] pix_col_q,     pix_col_d;
    logic [PIX_W-1:0] pix_data_q,    pix_data_d;
    logic             line_valid_q,  line_valid_d;
    logic [COL_W:0]   line_cols_q,   line_cols_d;
    logic [ROW_W-1:0] line_row_q,    line_row_d;
    logic [PL_W-1:0]  line_plane_q,  line_plane_d;
    logic             on_valid_q,    on_valid_d;
    logic [CNT_W-1:0] on_cycles_q,   on_cycles_d;
    logic [PL_W-1:0]  on_plane_q,    on_plane_d;
    logic             frame_start_q, frame_start_d;

    // Gather the colour lines into the pixel word layout.
    always_comb begin
        colour_s         = '0;
        colour_s[R1_BIT] = r1;
        colour_s[G1_BIT] = g1;
        colour_s[B1_BIT] = b1;
        colour_s[R2_BIT] = r2;
        colour_s[G2_BIT] = g2;
        colour_s[B2_BIT] = b2;
        colour_s[R3_BIT] = r3;
        colour_s[G3_BIT] = g3;
        colour_s[B3_BIT] = b3;
        colour_s[R4_BIT] = r4;
        colour_s[G4_BIT] = g4;
        colour_s[B4_BIT] = b4;
    end

    hub75_edge_det #(.DW(PIX_W), .RST_VAL(1'b0)) u_shift_edge (
        .clk(clk), .rst(rst), .sig_i(clk_out), .data_i(colour_s),
        .rise_o(shift_rise_s), .fall_o(shift_fall_s), .data_o(colour_sync_s)
    );

    hub75_edge_det #(.DW(1), .RST_VAL(1'b0)) u_lat_edge (
        .clk(clk), .rst(rst), .sig_i(lat), .data_i(1'b0),
        .rise_o(lat_rise_s), .fall_o(lat_fall_s), .data_o(lat_data_s)
    );

    hub75_edge_det #(.DW(1), .RST_VAL(1'b1)) u_blank_edge (
        .clk(clk), .rst(rst), .sig_i(blank), .data_i(1'b0),
        .rise_o(blank_rise_s), .fall_o(blank_fall_s), .data_o(blank_data_s)
    );

    hub75_edge_det #(.DW(1), .RST_VAL(1'b0)) u_row_edge (
        .clk(clk), .rst(rst), .sig_i(row_clk), .data_i(row_data),
        .rise_o(row_rise_s), .fall_o(row_fall_s), .data_o(row_data_s)
    );

    assign unused_s = &{1'b0, shift_fall_s, lat_fall_s, lat_data_s, blank_data_s, row_fall_s};

    // Row token position after a shift; lowest set bit wins, an empty register keeps the old row.
    always_comb begin
        row_shift_s = {row_sr_q[ROWS-2:0], row_data_s};
        row_enc_s   = row_idx_q;
        for (int i = ROWS - 1; i >= 0; i--) begin
            row_enc_s = row_shift_s[i] ? ROW_W'(i) : row_enc_s;
        end
    end

    // Event processing in priority order pixel, line, row, then the on-time FSM.
    always_comb begin
        col_cnt_d     = col_cnt_q;
        plane_d       = plane_q;
        last_plane_d  = last_plane_q;
        lit_plane_d   = lit_plane_q;
        row_sr_d      = row_sr_q;
        row_idx_d     = row_idx_q;
        state_d       = state_q;
        on_cnt_d      = on_cnt_q;
        err_d         = err_q;
        pix_valid_d   = 1'b0;
        pix_col_d     = pix_col_q;
        pix_data_d    = pix_data_q;
        line_valid_d  = 1'b0;
        line_cols_d   = line_cols_q;
        line_row_d    = line_row_q;
        line_plane_d  = line_plane_q;
        on_valid_d    = 1'b0;
        on_cycles_d   = on_cycles_q;
        on_plane_d    = on_plane_q;
        frame_start_d = 1'b0;

        if (shift_rise_s) begin
            pix_valid_d = 1'b1;
            pix_data_d  = colour_sync_s;
            if (col_cnt_q == COL_FULL) begin
                pix_col_d          = COL_LAST;
                err_d[ERR_COL_OVF] = 1'b1;
            end else begin
                pix_col_d = col_cnt_q[COL_W-1:0];
                col_cnt_d = col_cnt_q + COL_INC;
            end
        end else begin
            pix_valid_d = 1'b0;
        end

        if (lat_rise_s) begin
            line_valid_d = 1'b1;
            line_cols_d  = col_cnt_d;
            line_row_d   = row_idx_q;
            line_plane_d = plane_q;
            last_plane_d = plane_q;
            plane_d      = plane_q + PL_INC;
            col_cnt_d    = '0;
            if (!onehot32(32'(row_sr_q))) begin
                err_d[ERR_ROW_ONEHOT] = 1'b1;
            end else begin
                err_d[ERR_ROW_ONEHOT] = err_q[ERR_ROW_ONEHOT];
            end
            if (state_q == ST_LIT) begin
                err_d[ERR_LAT_LIT] = 1'b1;
            end else begin
                err_d[ERR_LAT_LIT] = err_q[ERR_LAT_LIT];
            end
        end else begin
            line_valid_d = 1'b0;
        end

        if (row_rise_s) begin
            row_sr_d  = row_shift_s;
            row_idx_d = row_enc_s;
            if (row_enc_s != row_idx_q) begin
                plane_d = '0;
            end else begin
                plane_d = plane_d;
            end
            if ((row_idx_q == ROW_LAST) && (row_enc_s == '0)) begin
                frame_start_d = 1'b1;
            end else begin
                frame_start_d = 1'b0;
            end
        end else begin
            row_sr_d = row_sr_q;
        end

        case (state_q)
            ST_DARK: begin
                if (blank_fall_s) begin
                    state_d     = ST_LIT;
                    on_cnt_d    = CNT_ONE;
                    lit_plane_d = last_plane_d;
                end else begin
                    state_d = ST_DARK;
                end
            end
            ST_LIT: begin
                if (blank_rise_s) begin
                    state_d     = ST_DARK;
                    on_valid_d  = 1'b1;
                    on_cycles_d = on_cnt_q;
                    on_plane_d  = lit_plane_q;
                end else if (on_cnt_q != CNT_MAX) begin
                    on_cnt_d = on_cnt_q + CNT_ONE;
                end else begin
                    on_cnt_d = on_cnt_q;
                end
            end
            default: begin
                state_d = ST_DARK;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_cnt_q     <= '0;
            plane_q       <= '0;
            last_plane_q  <= '0;
            lit_plane_q   <= '0;
            row_sr_q      <= '0;
            row_idx_q     <= '0;
            state_q       <= ST_DARK;
            on_cnt_q      <= '0;
            err_q         <= '0;
            pix_valid_q   <= 1'b0;
            pix_col_q     <= '0;
            pix_data_q    <= '0;
            line_valid_q  <= 1'b0;
            line_cols_q   <= '0;
            line_row_q    <= '0;
            line_plane_q  <= '0;
            on_valid_q    <= 1'b0;
            on_cycles_q   <= '0;
            on_plane_q    <= '0;
            frame_start_q <= 1'b0;
        end else begin
            col_cnt_q     <= col_cnt_d;
            plane_q       <= plane_d;
            last_plane_q  <= last_plane_d;
            lit_plane_q   <= lit_plane_d;
            row_sr_q      <= row_sr_d;
            row_idx_q     <= row_idx_d;
            state_q       <= state_d;
            on_cnt_q      <= on_cnt_d;
            err_q         <= err_d;
            pix_valid_q   <= pix_valid_d;
            pix_col_q     <= pix_col_d;
            pix_data_q    <= pix_data_d;
            line_valid_q  <= line_valid_d;
            line_cols_q   <= line_cols_d;
            line_row_q    <= line_row_d;
            line_plane_q  <= line_plane_d;
            on_valid_q    <= on_valid_d;
            on_cycles_q   <= on_cycles_d;
            on_plane_q    <= on_plane_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign pix_valid   = pix_valid_q;
    assign pix_col     = pix_col_q;
    assign pix_data    = pix_data_q;
    assign line_valid  = line_valid_q;
    assign line_cols   = line_cols_q;
    assign line_row    = line_row_q;
    assign line_plane  = line_plane_q;
    assign on_valid    = on_valid_q;
    assign on_cycles   = on_cycles_q;
    assign on_plane    = on_plane_q;
    assign frame_start = frame_start_q;
    assign err         = err_q;

endmodule

// File: tb/tb_hub75_rx_monitor.sv
// Self-checking bench for hub75_rx_monitor: randomized panel traffic against a transaction-level model.
module tb_hub75_rx_monitor;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [11:0] col_bus = 12'd0;
    logic        clk_out = 1'b0;
    logic        lat = 1'b0;
    logic        blank = 1'b1;
    logic        row_clk = 1'b0;
    logic        row_data = 1'b0;

    logic        pix_valid;
    logic [6:0]  pix_col;
    logic [11:0] pix_data;
    logic        line_valid;
    logic [7:0]  line_cols;
    logic [3:0]  line_row;
    logic [3:0]  line_plane;
    logic        on_valid;
    logic [15:0] on_cycles;
    logic [3:0]  on_plane;
    logic        frame_start;
    logic [2:0]  err;

    hub75_rx_monitor dut (
        .clk(clk), .rst(rst),
        .r1(col_bus[0]), .g1(col_bus[1]), .b1(col_bus[2]),
        .r2(col_bus[3]), .g2(col_bus[4]), .b2(col_bus[5]),
        .r3(col_bus[6]), .g3(col_bus[7]), .b3(col_bus[8]),
        .r4(col_bus[9]), .g4(col_bus[10]), .b4(col_bus[11]),
        .clk_out(clk_out), .lat(lat), .blank(blank), .row_clk(row_clk), .row_data(row_data),
        .pix_valid(pix_valid), .pix_col(pix_col), .pix_data(pix_data),
        .line_valid(line_valid), .line_cols(line_cols), .line_row(line_row), .line_plane(line_plane),
        .on_valid(on_valid), .on_cycles(on_cycles), .on_plane(on_plane),
        .frame_start(frame_start), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct { int col; logic [11:0] data; int cyc; } pix_t;
    typedef struct { int cols; int row; int plane; int cyc; } line_t;
    typedef struct { int cycles; int plane; } on_t;

    pix_t  got_pix[$],  exp_pix[$];
    line_t got_line[$], exp_line[$];
    on_t   got_on[$],   exp_on[$];
    int    got_fs, exp_fs;
    int    cyc = 0;
    int    n_vec = 0;
    int    n_bad = 0;

    // Transaction-level model of what the panel bus should decode to.
    int          m_col, m_plane, m_last_plane, m_lit_plane, m_row_idx;
    logic [15:0] m_row_sr;
    bit          m_lit;
    logic [2:0]  m_err;

    always @(posedge clk) cyc = cyc + 1;

    always @(negedge clk) begin
        if (!rst) begin
            if (pix_valid) got_pix.push_back('{int'(pix_col), pix_data, cyc});
            if (line_valid) got_line.push_back('{int'(line_cols), int'(line_row), int'(line_plane), cyc});
            if (on_valid) got_on.push_back('{int'(on_cycles), int'(on_plane)});
            if (frame_start) got_fs = got_fs + 1;
        end
    end

    function void m_reset();
        m_col = 0; m_plane = 0; m_last_plane = 0; m_lit_plane = 0; m_row_idx = 0;
        m_row_sr = 16'd0; m_lit = 1'b0; m_err = 3'd0;
    endfunction

    function void clear_q();
        got_pix.delete(); exp_pix.delete(); got_line.delete(); exp_line.delete();
        got_on.delete(); exp_on.delete(); got_fs = 0; exp_fs = 0;
    endfunction

    function void m_pix(input logic [11:0] c);
        pix_t p;
        if (m_col >= 128) begin
            p.col = 127;
            m_err[0] = 1'b1;
        end else begin
            p.col = m_col;
            m_col = m_col + 1;
        end
        p.data = c;
        p.cyc = 0;
        exp_pix.push_back(p);
    endfunction

    function void m_latch();
        line_t l;
        l.cols = m_col; l.row = m_row_idx; l.plane = m_plane; l.cyc = 0;
        exp_line.push_back(l);
        m_last_plane = m_plane;
        m_plane = (m_plane + 1) % 16;
        m_col = 0;
        if (!$onehot(m_row_sr)) m_err[1] = 1'b1;
        if (m_lit) m_err[2] = 1'b1;
    endfunction

    function void m_row(input logic d);
        logic [15:0] s;
        int n;
        s = {m_row_sr[14:0], d};
        n = m_row_idx;
        for (int i = 15; i >= 0; i--) if (s[i]) n = i;
        if (n != m_row_idx) m_plane = 0;
        if (m_row_idx == 15 && n == 0) exp_fs = exp_fs + 1;
        m_row_idx = n;
        m_row_sr = s;
    endfunction

    task pix(input logic [11:0] c);
        @(negedge clk) col_bus = c; clk_out = 1'b1; m_pix(c);
        @(negedge clk) clk_out = 1'b0;
    endtask

    task do_lat();
        @(negedge clk) lat = 1'b1; m_latch();
        @(negedge clk) lat = 1'b0;
    endtask

    task pix_lat(input logic [11:0] c);
        @(negedge clk) col_bus = c; clk_out = 1'b1; lat = 1'b1; m_pix(c); m_latch();
        @(negedge clk) clk_out = 1'b0; lat = 1'b0;
    endtask

    task row_pulse(input logic d);
        @(negedge clk) row_data = d; row_clk = 1'b1; m_row(d);
        @(negedge clk) row_clk = 1'b0;
    endtask

    task lit(input int n, input int lat_at);
        on_t o;
        @(negedge clk) blank = 1'b0; m_lit = 1'b1; m_lit_plane = m_last_plane;
        for (int i = 1; i < n; i++) begin
            @(negedge clk) lat = (i == lat_at);
            if (i == lat_at) m_latch();
        end
        @(negedge clk) blank = 1'b1; lat = 1'b0; m_lit = 1'b0;
        o.cycles = (n > 65535) ? 65535 : n;
        o.plane = m_lit_plane;
        exp_on.push_back(o);
    endtask

    task settle();
        repeat (8) @(negedge clk);
    endtask

    task test_reset();
        logic [61:0] outs;
        repeat (3) @(negedge clk);
        outs = {pix_valid, pix_col, pix_data, line_valid, line_cols, line_row, line_plane,
                on_valid, on_cycles, on_plane, frame_start, err};
        n_vec++;
        if (outs !== 62'd0) begin
            n_bad++;
            $display("FAIL reset_outputs: got %h required 0", outs);
        end
        rst = 1'b0;
        m_reset();
        clear_q();
        settle();
        n_vec++;
        if (err !== 3'd0 || got_pix.size() != 0 || got_on.size() != 0) begin
            n_bad++;
            $display("FAIL reset_idle: err %0d pix %0d on %0d, required all 0", err, got_pix.size(), got_on.size());
        end
    endtask

    task test_rows();
        clear_q();
        row_pulse(1'b1);
        do_lat();
        for (int i = 0; i < 15; i++) begin
            row_pulse(1'b0);
            do_lat();
        end
        row_pulse(1'b1);
        do_lat();
        settle();
        n_vec++;
        if (got_line.size() != 17) begin
            n_bad++;
            $display("FAIL row_line_count: got %0d required 17", got_line.size());
        end
        for (int i = 0; i < 17 && i < got_line.size(); i++) begin
            n_vec++;
            if (got_line[i].row != exp_line[i].row || got_line[i].row != (i % 16) || got_line[i].plane != exp_line[i].plane) begin
                n_bad++;
                $display("FAIL line_row[%0d]: got row %0d plane %0d required row %0d plane %0d",
                         i, got_line[i].row, got_line[i].plane, i % 16, exp_line[i].plane);
            end
        end
        n_vec++;
        if (got_fs != exp_fs || got_fs != 1) begin
            n_bad++;
            $display("FAIL frame_start_count: got %0d required 1", got_fs);
        end
        n_vec++;
        if (err !== m_err) begin
            n_bad++;
            $display("FAIL rows_err: got %b required %b", err, m_err);
        end
    endtask

    task test_pixels();
        logic [11:0] c;
        logic        r1_exp;
        clear_q();
        for (int i = 0; i < 128; i++) begin
            r1_exp = (i % 2 == 0);
            c = (12'($urandom) & 12'hFFE) | {11'd0, r1_exp};
            pix(c);
        end
        do_lat();
        settle();
        n_vec++;
        if (got_pix.size() != 128) begin
            n_bad++;
            $display("FAIL pix_count: got %0d required 128", got_pix.size());
        end
        for (int i = 0; i < 128 && i < got_pix.size(); i++) begin
            r1_exp = (i % 2 == 0);
            n_vec++;
            if (got_pix[i].col != exp_pix[i].col || got_pix[i].data !== exp_pix[i].data || got_pix[i].data[0] !== r1_exp) begin
                n_bad++;
                $display("FAIL pix[%0d]: got col %0d data %h required col %0d data %h",
                         i, got_pix[i].col, got_pix[i].data, exp_pix[i].col, exp_pix[i].data);
            end
        end
        n_vec++;
        if (got_line.size() != 1 || got_line[0].cols != 128) begin
            n_bad++;
            $display("FAIL line_cols_full: got %0d lines, cols %0d required 1 line, 128", got_line.size(),
                     got_line.size() > 0 ? got_line[0].cols : -1);
        end
        n_vec++;
        if (err !== 3'd0) begin
            n_bad++;
            $display("FAIL pixels_err: got %b required 000", err);
        end
    endtask

    task test_overflow();
        clear_q();
        for (int i = 0; i < 129; i++) pix(12'($urandom));
        do_lat();
        settle();
        n_vec++;
        if (got_pix.size() != 129 || got_pix[got_pix.size()-1].col != 127 || got_pix[got_pix.size()-1].data !== exp_pix[128].data) begin
            n_bad++;
            $display("FAIL overflow_pix: got %0d pixels, last col %0d required 129, 127", got_pix.size(),
                     got_pix.size() > 0 ? got_pix[got_pix.size()-1].col : -1);
        end
        n_vec++;
        if (got_line.size() != 1 || got_line[0].cols != exp_line[0].cols) begin
            n_bad++;
            $display("FAIL overflow_line_cols: got %0d required %0d",
                     got_line.size() > 0 ? got_line[0].cols : -1, exp_line[0].cols);
        end
        n_vec++;
        if (err !== m_err || err[0] !== 1'b1) begin
            n_bad++;
            $display("FAIL overflow_err: got %b required %b", err, m_err);
        end
    endtask

    task test_on_time();
        clear_q();
        while (m_plane != 3) do_lat();
        do_lat();
        lit(37, 0);
        for (int k = 0; k < 3; k++) lit($urandom_range(1, 60), 0);
        do_lat();
        lit(10, 4);
        settle();
        n_vec++;
        if (got_on.size() != exp_on.size()) begin
            n_bad++;
            $display("FAIL on_count: got %0d required %0d", got_on.size(), exp_on.size());
        end
        for (int i = 0; i < exp_on.size() && i < got_on.size(); i++) begin
            n_vec++;
            if (got_on[i].cycles != exp_on[i].cycles || got_on[i].plane != exp_on[i].plane) begin
                n_bad++;
                $display("FAIL on_period[%0d]: got cycles %0d plane %0d required cycles %0d plane %0d",
                         i, got_on[i].cycles, got_on[i].plane, exp_on[i].cycles, exp_on[i].plane);
            end
        end
        n_vec++;
        if (got_on.size() == 0 || got_on[0].cycles != 37 || got_on[0].plane != 3) begin
            n_bad++;
            $display("FAIL on_37_plane3: got cycles %0d plane %0d required 37, 3",
                     got_on.size() > 0 ? got_on[0].cycles : -1, got_on.size() > 0 ? got_on[0].plane : -1);
        end
        n_vec++;
        if (err !== m_err || err[2] !== 1'b1) begin
            n_bad++;
            $display("FAIL lat_while_lit_err: got %b required %b", err, m_err);
        end
    endtask

    task test_simultaneous();
        clear_q();
        for (int i = 0; i < 5; i++) pix(12'($urandom));
        pix_lat(12'($urandom));
        settle();
        n_vec++;
        if (got_pix.size() != 6 || got_line.size() != 1) begin
            n_bad++;
            $display("FAIL simul_counts: got %0d pixels %0d lines required 6, 1", got_pix.size(), got_line.size());
        end else begin
            n_vec++;
            if (got_pix[5].col != 5 || got_line[0].cols != 6 || got_pix[5].cyc != got_line[0].cyc) begin
                n_bad++;
                $display("FAIL simul_pix_line: got col %0d cols %0d cycles %0d/%0d required 5, 6, same cycle",
                         got_pix[5].col, got_line[0].cols, got_pix[5].cyc, got_line[0].cyc);
            end
        end
    endtask

    task test_random();
        int op, n;
        clear_q();
        for (int k = 0; k < 80; k++) begin
            op = $urandom_range(0, 4);
            case (op)
                0: begin
                    n = $urandom_range(1, 24);
                    for (int j = 0; j < n; j++) pix(12'($urandom));
                end
                1: do_lat();
                2: row_pulse(m_row_sr[15]);
                3: begin
                    n = $urandom_range(1, 40);
                    lit(n, (n > 2 && $urandom_range(0, 3) == 0) ? $urandom_range(1, n - 1) : 0);
                end
                default: pix_lat(12'($urandom));
            endcase
        end
        settle();
        n_vec++;
        if (got_pix.size() != exp_pix.size() || got_line.size() != exp_line.size() || got_on.size() != exp_on.size()) begin
            n_bad++;
            $display("FAIL random_counts: got pix %0d line %0d on %0d required %0d %0d %0d", got_pix.size(),
                     got_line.size(), got_on.size(), exp_pix.size(), exp_line.size(), exp_on.size());
        end
        for (int i = 0; i < exp_pix.size() && i < got_pix.size(); i++) begin
            n_vec++;
            if (got_pix[i].col != exp_pix[i].col || got_pix[i].data !== exp_pix[i].data) begin
                n_bad++;
                $display("FAIL random_pix[%0d]: got %0d/%h required %0d/%h", i, got_pix[i].col,
                         got_pix[i].data, exp_pix[i].col, exp_pix[i].data);
            end
        end
        for (int i = 0; i < exp_line.size() && i < got_line.size(); i++) begin
            n_vec++;
            if (got_line[i].cols != exp_line[i].cols || got_line[i].row != exp_line[i].row || got_line[i].plane != exp_line[i].plane) begin
                n_bad++;
                $display("FAIL random_line[%0d]: got %0d/%0d/%0d required %0d/%0d/%0d", i, got_line[i].cols,
                         got_line[i].row, got_line[i].plane, exp_line[i].cols, exp_line[i].row, exp_line[i].plane);
            end
        end
        for (int i = 0; i < exp_on.size() && i < got_on.size(); i++) begin
            n_vec++;
            if (got_on[i].cycles != exp_on[i].cycles || got_on[i].plane != exp_on[i].plane) begin
                n_bad++;
                $display("FAIL random_on[%0d]: got %0d/%0d required %0d/%0d", i, got_on[i].cycles,
                         got_on[i].plane, exp_on[i].cycles, exp_on[i].plane);
            end
        end
        n_vec++;
        if (got_fs != exp_fs || err !== m_err) begin
            n_bad++;
            $display("FAIL random_fs_err: got fs %0d err %b required fs %0d err %b", got_fs, err, exp_fs, m_err);
        end
    endtask

    task test_saturation();
        clear_q();
        lit(70000, 0);
        settle();
        n_vec++;
        if (got_on.size() != 1 || got_on[0].cycles != 65535) begin
            n_bad++;
            $display("FAIL on_saturate: got %0d periods, cycles %0d required 1, 65535", got_on.size(),
                     got_on.size() > 0 ? got_on[0].cycles : -1);
        end
    endtask

    task test_mid_reset();
        logic [61:0] outs;
        clear_q();
        for (int i = 0; i < 40; i++) pix(12'($urandom));
        @(negedge clk) blank = 1'b0;
        repeat (5) @(negedge clk);
        #2 rst = 1'b1;
        #1 outs = {pix_valid, pix_col, pix_data, line_valid, line_cols, line_row, line_plane,
                   on_valid, on_cycles, on_plane, frame_start, err};
        n_vec++;
        if (outs !== 62'd0) begin
            n_bad++;
            $display("FAIL mid_reset_outputs: got %h required 0", outs);
        end
        @(negedge clk) blank = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        m_reset();
        clear_q();
        row_pulse(1'b1);
        pix(12'($urandom));
        do_lat();
        settle();
        n_vec++;
        if (got_pix.size() != 1 || got_pix[0].col != 0 || got_on.size() != 0) begin
            n_bad++;
            $display("FAIL mid_reset_restart: got %0d pixels col %0d, %0d on periods required 1, 0, 0",
                     got_pix.size(), got_pix.size() > 0 ? got_pix[0].col : -1, got_on.size());
        end
        n_vec++;
        if (got_line.size() != 1 || got_line[0].cols != 1 || err !== 3'd0) begin
            n_bad++;
            $display("FAIL mid_reset_line: got %0d lines cols %0d err %b required 1, 1, 000",
                     got_line.size(), got_line.size() > 0 ? got_line[0].cols : -1, err);
        end
    endtask

    initial begin
        m_reset();
        test_reset();
        test_rows();
        test_pixels();
        test_simultaneous();
        test_overflow();
        test_on_time();
        test_random();
        test_saturation();
        test_mid_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
